gcl_config_sequencer: RTL and testbench
=======================================

// Module: gcl_config_sequencer
// PURPOSE
// Owns the admin (shadow) gate control list and sequences its transfer into list_execute_sm's operational GCL.
// The host writes gate/interval entries into the shadow copy at any time outside a load.
// At a requested PTP config-change time, the block waits for the next CycleStart and streams all entries over
// the gcl_ld / gcl_time_ld ports, then reports the new operational cycle length.
// Sits between the host register block and list_execute_sm; list_execute_sm's gcl_clk_in is driven by clk.
// PARAMETERS
// NUM_ENTRIES  16  GCL depth; entries 0..NUM_ENTRIES-1
// ID_W         4   entry index width; must satisfy 2**ID_W >= NUM_ENTRIES
// GATE_W       9   gate-state word width
// TIME_W       20  interval width, in ns
// LD_GAP       1   idle cycles inserted after each load strobe; 0..7
// PORTS
// clk                   in   1             system clock, 125 MHz
// rst                   in   1             synchronous, active-high reset
// adm_wr                in   1             shadow-list write strobe
// adm_wr_sel            in   1             0 = gate word, 1 = interval
// adm_wr_id             in   ID_W          entry index
// adm_wr_data           in   TIME_W        data; gate writes use [GATE_W-1:0]
// cfg_change_req        in   1             arm a config change (one-cycle pulse)
// cfg_change_time       in   64            PTP ns at which the change is allowed; sampled with cfg_change_req
// sync_time_ptp_ns_mini in   64            current PTP time in ns
// CycleStart            in   1             cycle-boundary pulse from the cycle timer
// gcl_ld                out  1             gate-entry load strobe
// gcl_id                out  ID_W          gate-entry index
// gcl_ld_data           out  GATE_W        gate-entry data
// gcl_time_ld           out  1             interval load strobe
// gcl_time_id           out  ID_W          interval index
// gcl_ld_time           out  TIME_W        interval data
// cfg_pending           out  1             change armed, load not yet started
// cfg_busy              out  1             load in progress
// cfg_done              out  1             one-cycle pulse when the load completes
// cfg_err               out  1             one-cycle pulse on a rejected write or request
// oper_cycle_time       out  TIME_W+ID_W   sum of the loaded intervals, in ns
// BEHAVIOUR
// Reset: state IDLE; all outputs 0; shadow gate and interval arrays cleared to 0.
// Reset mid-load abandons the load immediately; no further strobes are issued.
// States:
// - IDLE: cfg_change_req -> PEND.
// - PEND: cfg_pending=1. When sync_time_ptp_ns_mini >= the latched time -> WAIT_CS.
//   A request whose time is already <= current PTP time reaches WAIT_CS on the next cycle.
// - WAIT_CS: cfg_pending=1. On a CycleStart cycle -> LOAD_G with idx=0. The first strobe occurs the cycle after CycleStart.
// - LOAD_G: cfg_busy=1. Gate loads, then LOAD_T.
// - LOAD_T: cfg_busy=1. Interval loads, then DONE.
// - DONE: cfg_done=1 for 1 cycle; oper_cycle_time updated in the same cycle; -> IDLE.
// Load sequencing:
// - Each entry: 1 strobe cycle (gcl_ld or gcl_time_ld = 1, id/data valid), then LD_GAP idle cycles with strobe, id and data all 0.
// - LOAD_G covers idx 0..NUM_ENTRIES-1, then LOAD_T covers idx 0..NUM_ENTRIES-1. idx wraps to 0 between the two phases.
// - Never more than one strobe per cycle.
// - Total busy cycles = 2*NUM_ENTRIES*(1+LD_GAP).
// Cycle-time accumulator:
// - Cleared on entry to LOAD_T; adds each interval as it is strobed.
// - Width TIME_W+ID_W, so no overflow for any contents.
// - oper_cycle_time holds its last value until the next DONE.
// Shadow writes:
// - Accepted in IDLE, PEND and WAIT_CS; take effect immediately, so the latest value is loaded.
// - In LOAD_G, LOAD_T or DONE: the write is dropped and cfg_err pulses.
// - adm_wr_id >= NUM_ENTRIES: dropped, cfg_err pulses.
// Change requests:
// - cfg_change_req in PEND or WAIT_CS: re-latches the time and returns to PEND (latest request wins), no error.
// - cfg_change_req in a LOAD state or DONE: ignored, cfg_err pulses.
// - Simultaneous adm_wr and cfg_change_req in IDLE: both accepted; the write is visible to the load.
// - CycleStart outside WAIT_CS is ignored.
// TESTING
// T1 reset: hold rst 16 cycles mid-load -> next cycle all strobes 0, cfg_busy=0, oper_cycle_time=0; a later load emits shadow contents 0.
// T2 basic: gate[i]=i; time[0]=0x35B0, time[1]=0xD0, time[2]=0x980, others 0; change_time=now+1000 ->
//    gcl_ld id 0..15 with data 0..15 every 2 cycles, then gcl_time_ld id 0..15; cfg_done after 64 busy cycles;
//    oper_cycle_time=0x4000.
// T3 timing: change_time=0x300_0000 -> no strobe before PTP>=0x300_0000; first gcl_ld exactly 1 cycle after the following CycleStart.
// T4 past time: change_time=0 -> WAIT_CS next cycle; load starts after the first CycleStart.
// T5 errors: adm_wr during LOAD_T -> cfg_err pulse and shadow unchanged (reload shows old value);
//    adm_wr_id=15 with NUM_ENTRIES=8 -> cfg_err; cfg_change_req during busy -> cfg_err, load unaffected.
// T6 re-arm: request at T=5000, then at T=9000 while in PEND -> load begins only after PTP>=9000 and the next CycleStart;
//    all intervals 0xFFFFF -> oper_cycle_time=0xFFFFF0.

Source files
------------

// File: rtl/gcl_config_sequencer_if.sv
// Host-side bus of the GCL config sequencer: shadow-list writes, change requests,
// PTP time / CycleStart inputs and the load port towards list_execute_sm.
interface gcl_config_sequencer_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned GATE_W = 9,
    parameter int unsigned TIME_W = 20
) ();
    logic                   adm_wr;
    logic                   adm_wr_sel;
    logic [ID_W-1:0]        adm_wr_id;
    logic [TIME_W-1:0]      adm_wr_data;
    logic                   cfg_change_req;
    logic [63:0]            cfg_change_time;
    logic [63:0]            sync_time_ptp_ns_mini;
    logic                   CycleStart;
    logic                   gcl_ld;
    logic [ID_W-1:0]        gcl_id;
    logic [GATE_W-1:0]      gcl_ld_data;
    logic                   gcl_time_ld;
    logic [ID_W-1:0]        gcl_time_id;
    logic [TIME_W-1:0]      gcl_ld_time;
    logic                   cfg_pending;
    logic                   cfg_busy;
    logic                   cfg_done;
    logic                   cfg_err;
    logic [TIME_W+ID_W-1:0] oper_cycle_time;

    modport master (
        output adm_wr, adm_wr_sel, adm_wr_id, adm_wr_data, cfg_change_req, cfg_change_time,
               sync_time_ptp_ns_mini, CycleStart,
        input  gcl_ld, gcl_id, gcl_ld_data, gcl_time_ld, gcl_time_id, gcl_ld_time,
               cfg_pending, cfg_busy, cfg_done, cfg_err, oper_cycle_time
    );

    modport slave (
        input  adm_wr, adm_wr_sel, adm_wr_id, adm_wr_data, cfg_change_req, cfg_change_time,
               sync_time_ptp_ns_mini, CycleStart,
        output gcl_ld, gcl_id, gcl_ld_data, gcl_time_ld, gcl_time_id, gcl_ld_time,
               cfg_pending, cfg_busy, cfg_done, cfg_err, oper_cycle_time
    );
endinterface

// File: rtl/gcl_config_sequencer.sv
// Owns the admin (shadow) gate control list and, at a requested PTP time, waits for
// the next CycleStart and streams every gate entry then every interval into
// list_execute_sm, finally reporting the new operational cycle length.
module gcl_config_sequencer #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned GATE_W      = 9,
    parameter int unsigned TIME_W      = 20,
    parameter int unsigned LD_GAP      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    gcl_config_sequencer_if.slave bus
);
    localparam int unsigned ACC_W = TIME_W + ID_W;

    typedef enum logic [2:0] {IDLE, PEND, WAIT_CS, LOAD_G, LOAD_T, DONE} state_t;

    state_t              state_q, state_d;
    logic [63:0]         chg_time_q, chg_time_d;
    logic [ID_W-1:0]     idx_q, idx_d;
    logic [2:0]          gap_q, gap_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    oper_q, oper_d;
    logic [GATE_W-1:0]   gate_mem_q [NUM_ENTRIES];
    logic [GATE_W-1:0]   gate_mem_d [NUM_ENTRIES];
    logic [TIME_W-1:0]   time_mem_q [NUM_ENTRIES];
    logic [TIME_W-1:0]   time_mem_d [NUM_ENTRIES];
    logic                ld_q, ld_d, tld_q, tld_d;
    logic [ID_W-1:0]     id_q, id_d, tid_q, tid_d;
    logic [GATE_W-1:0]   ld_data_q, ld_data_d;
    logic [TIME_W-1:0]   ld_time_q, ld_time_d;
    logic                pending_q, pending_d, busy_q, busy_d;
    logic                done_q, done_d, err_q, err_d;

    logic                in_load, id_ok, entry_done, last_entry;
    logic [ID_W-1:0]     nxt_idx;

    // Next-state, shadow-write and load-strobe computation; outputs are registered from the _d values.
    always_comb begin
        state_d    = state_q;
        chg_time_d = chg_time_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        acc_d      = acc_q;
        oper_d     = oper_q;
        gate_mem_d = gate_mem_q;
        time_mem_d = time_mem_q;
        ld_d       = 1'b0;
        id_d       = '0;
        ld_data_d  = '0;
        tld_d      = 1'b0;
        tid_d      = '0;
        ld_time_d  = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        in_load    = (state_q == LOAD_G) || (state_q == LOAD_T) || (state_q == DONE);
        id_ok      = 32'(bus.adm_wr_id) < NUM_ENTRIES;
        entry_done = 32'(gap_q) == LD_GAP;
        last_entry = 32'(idx_q) == NUM_ENTRIES - 1;
        nxt_idx    = idx_q + 1'b1;

        if (bus.adm_wr) begin
            if (in_load || !id_ok) begin
                err_d = 1'b1;
            end else if (bus.adm_wr_sel) begin
                time_mem_d[bus.adm_wr_id] = bus.adm_wr_data;
            end else begin
                gate_mem_d[bus.adm_wr_id] = bus.adm_wr_data[GATE_W-1:0];
            end
        end
        if (bus.cfg_change_req && in_load) begin
            err_d = 1'b1;
        end

        // Strobe data is taken from the post-write arrays so a same-cycle write is loaded.
        case (state_q)
            IDLE, PEND, WAIT_CS: begin
                if (bus.cfg_change_req) begin
                    state_d    = PEND;
                    chg_time_d = bus.cfg_change_time;
                end else if (state_q == PEND && bus.sync_time_ptp_ns_mini >= chg_time_q) begin
                    state_d = WAIT_CS;
                end else if (state_q == WAIT_CS && bus.CycleStart) begin
                    state_d   = LOAD_G;
                    idx_d     = '0;
                    gap_d     = '0;
                    ld_d      = 1'b1;
                    ld_data_d = gate_mem_d[0];
                end
            end
            LOAD_G: begin
                if (!entry_done) begin
                    gap_d = gap_q + 3'd1;
                end else if (last_entry) begin
                    state_d   = LOAD_T;
                    idx_d     = '0;
                    gap_d     = '0;
                    tld_d     = 1'b1;
                    ld_time_d = time_mem_d[0];
                    acc_d     = ACC_W'(time_mem_d[0]);
                end else begin
                    idx_d     = nxt_idx;
                    gap_d     = '0;
                    ld_d      = 1'b1;
                    id_d      = nxt_idx;
                    ld_data_d = gate_mem_d[nxt_idx];
                end
            end
            LOAD_T: begin
                if (!entry_done) begin
                    gap_d = gap_q + 3'd1;
                end else if (last_entry) begin
                    state_d = DONE;
                    idx_d   = '0;
                    gap_d   = '0;
                    done_d  = 1'b1;
                    oper_d  = acc_q;
                end else begin
                    idx_d     = nxt_idx;
                    gap_d     = '0;
                    tld_d     = 1'b1;
                    tid_d     = nxt_idx;
                    ld_time_d = time_mem_d[nxt_idx];
                    acc_d     = acc_q + ACC_W'(time_mem_d[nxt_idx]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pending_d = (state_d == PEND) || (state_d == WAIT_CS);
        busy_d    = (state_d == LOAD_G) || (state_d == LOAD_T);
    end

    // State, shadow arrays and registered outputs; reset abandons any load in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            chg_time_q <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            acc_q      <= '0;
            oper_q     <= '0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                gate_mem_q[i] <= '0;
                time_mem_q[i] <= '0;
            end
            ld_q       <= 1'b0;
            id_q       <= '0;
            ld_data_q  <= '0;
            tld_q      <= 1'b0;
            tid_q      <= '0;
            ld_time_q  <= '0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chg_time_q <= chg_time_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            acc_q      <= acc_d;
            oper_q     <= oper_d;
            gate_mem_q <= gate_mem_d;
            time_mem_q <= time_mem_d;
            ld_q       <= ld_d;
            id_q       <= id_d;
            ld_data_q  <= ld_data_d;
            tld_q      <= tld_d;
            tid_q      <= tid_d;
            ld_time_q  <= ld_time_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.gcl_ld          = ld_q;
    assign bus.gcl_id          = id_q;
    assign bus.gcl_ld_data     = ld_data_q;
    assign bus.gcl_time_ld     = tld_q;
    assign bus.gcl_time_id     = tid_q;
    assign bus.gcl_ld_time     = ld_time_q;
    assign bus.cfg_pending     = pending_q;
    assign bus.cfg_busy        = busy_q;
    assign bus.cfg_done        = done_q;
    assign bus.cfg_err         = err_q;
    assign bus.oper_cycle_time = oper_q;
endmodule

// File: tb/tb_gcl_config_sequencer.sv
// Directed bench for gcl_config_sequencer: 16-entry instance with LD_GAP=1, plus an
// 8-entry instance used only for the out-of-range index check.
module tb_gcl_config_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [8:0]  exp_gate [16];
    logic [19:0] exp_time [16];

    always #4 clk = ~clk;

    gcl_config_sequencer_if #(.ID_W(4), .GATE_W(9), .TIME_W(20)) u_if ();
    gcl_config_sequencer_if #(.ID_W(4), .GATE_W(9), .TIME_W(20)) u_if8 ();

    gcl_config_sequencer #(
        .NUM_ENTRIES(16), .ID_W(4), .GATE_W(9), .TIME_W(20), .LD_GAP(1)
    ) u_dut (.clk(clk), .rst(rst), .bus(u_if));

    gcl_config_sequencer #(
        .NUM_ENTRIES(8), .ID_W(4), .GATE_W(9), .TIME_W(20), .LD_GAP(0)
    ) u_dut8 (.clk(clk), .rst(rst), .bus(u_if8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic b, input logic l, input logic [3:0] id,
                                         input logic [8:0] d, input logic tl, input logic [3:0] tid,
                                         input logic [19:0] t, input logic e, input logic p);
        return {22'b0, b, l, id, d, tl, tid, t, e, p};
    endfunction

    function automatic logic [63:0] obs();
        return pack(u_if.cfg_busy, u_if.gcl_ld, u_if.gcl_id, u_if.gcl_ld_data, u_if.gcl_time_ld,
                    u_if.gcl_time_id, u_if.gcl_ld_time, u_if.cfg_err, u_if.cfg_pending);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        u_if.sync_time_ptp_ns_mini = u_if.sync_time_ptp_ns_mini + 64'd8;
    endtask

    task automatic wr(input logic sel, input logic [3:0] id, input logic [19:0] data);
        u_if.adm_wr      = 1'b1;
        u_if.adm_wr_sel  = sel;
        u_if.adm_wr_id   = id;
        u_if.adm_wr_data = data;
        tick();
        u_if.adm_wr = 1'b0;
    endtask

    task automatic request(input logic [63:0] t);
        u_if.cfg_change_req  = 1'b1;
        u_if.cfg_change_time = t;
        tick();
        u_if.cfg_change_req = 1'b0;
    endtask

    task automatic pulse_cs();
        u_if.CycleStart = 1'b1;
        tick();
        u_if.CycleStart = 1'b0;
    endtask

    // Step until PTP reaches target (bounded), noting any load activity on the way.
    task automatic wait_ptp(input logic [63:0] target, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (u_if.sync_time_ptp_ns_mini >= target) break;
            seen = seen | u_if.cfg_busy | u_if.gcl_ld | u_if.gcl_time_ld;
            tick();
        end
        check("wait_ptp", {63'b0, u_if.sync_time_ptp_ns_mini >= target}, 64'd1);
    endtask

    // Checks all 64 busy cycles of one load against exp_gate/exp_time, optionally
    // injecting a shadow write (wr_at) or change request (req_at) at a given cycle.
    task automatic check_load(input int wr_at, input int req_at, input logic [23:0] oper_exp);
        int         e;
        logic       s, gl, tl;
        logic [3:0] ei;
        for (int c = 0; c < 64; c++) begin
            e  = (c % 32) / 2;
            ei = 4'(e);
            s  = (c % 2) == 0;
            gl = s && (c < 32);
            tl = s && (c >= 32);
            check($sformatf("load_c%0d", c), obs(),
                  pack(1'b1, gl, gl ? ei : 4'h0, gl ? exp_gate[e] : 9'h0,
                       tl, tl ? ei : 4'h0, tl ? exp_time[e] : 20'h0,
                       (c == wr_at + 1) || (c == req_at + 1), 1'b0));
            if (c == wr_at) begin
                u_if.adm_wr      = 1'b1;
                u_if.adm_wr_sel  = 1'b1;
                u_if.adm_wr_id   = 4'd3;
                u_if.adm_wr_data = 20'hABC;
            end
            if (c == req_at) begin
                u_if.cfg_change_req  = 1'b1;
                u_if.cfg_change_time = 64'd0;
            end
            tick();
            u_if.adm_wr         = 1'b0;
            u_if.cfg_change_req = 1'b0;
        end
        check("done_pulse", {63'b0, u_if.cfg_done}, 64'd1);
        check("done_vec", obs(), 64'd0);
        check("oper_cycle_time", {40'b0, u_if.oper_cycle_time}, {40'b0, oper_exp});
        tick();
        check("done_clear", {63'b0, u_if.cfg_done}, 64'd0);
        check("oper_hold", {40'b0, u_if.oper_cycle_time}, {40'b0, oper_exp});
    endtask

    initial begin
        logic seen;
        u_if.adm_wr = 0; u_if.adm_wr_sel = 0; u_if.adm_wr_id = 0; u_if.adm_wr_data = 0;
        u_if.cfg_change_req = 0; u_if.cfg_change_time = 0; u_if.sync_time_ptp_ns_mini = 64'd1000;
        u_if.CycleStart = 0;
        u_if8.adm_wr = 0; u_if8.adm_wr_sel = 0; u_if8.adm_wr_id = 0; u_if8.adm_wr_data = 0;
        u_if8.cfg_change_req = 0; u_if8.cfg_change_time = 0; u_if8.sync_time_ptp_ns_mini = 0;
        u_if8.CycleStart = 0;

        // Reset state
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        check("rst_vec", obs(), 64'd0);
        check("rst_oper", {40'b0, u_if.oper_cycle_time}, 64'd0);
        check("rst_done", {63'b0, u_if.cfg_done}, 64'd0);

        // T2 basic load
        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 4'(i), 20'(i));
            exp_gate[i] = 9'(i);
            exp_time[i] = 20'h0;
        end
        wr(1'b1, 4'd0, 20'h35B0);
        wr(1'b1, 4'd1, 20'h000D0);
        wr(1'b1, 4'd2, 20'h00980);
        exp_time[0] = 20'h35B0; exp_time[1] = 20'hD0; exp_time[2] = 20'h980;
        request(u_if.sync_time_ptp_ns_mini + 64'd1000);
        check("t2_pending", {63'b0, u_if.cfg_pending}, 64'd1);
        wait_ptp(u_if.cfg_change_time + 64'd24, seen);
        check("t2_no_early", {63'b0, seen}, 64'd0);
        pulse_cs();
        check_load(100, 100, 24'h004000);

        // T1 reset mid-load
        request(64'd0);
        tick();
        pulse_cs();
        repeat (10) tick();
        check("t1_busy", {63'b0, u_if.cfg_busy}, 64'd1);
        rst = 1'b1;
        tick();
        check("t1_rst_vec", obs(), 64'd0);
        check("t1_rst_oper", {40'b0, u_if.oper_cycle_time}, 64'd0);
        repeat (15) tick();
        rst = 1'b0;
        tick();
        check("t1_idle_vec", obs(), 64'd0);
        for (int i = 0; i < 16; i++) begin
            exp_gate[i] = 9'h0;
            exp_time[i] = 20'h0;
        end
        request(64'd0);
        tick();
        pulse_cs();
        check_load(100, 100, 24'h0);

        // T4 past time, T5 errors during load
        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 4'(i), 20'(i * 3));
            wr(1'b1, 4'(i), 20'h10);
            exp_gate[i] = 9'(i * 3);
            exp_time[i] = 20'h10;
        end
        request(64'd0);
        check("t4_pend", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        check("t4_wait_cs", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
        pulse_cs();
        check_load(40, 10, 24'h000100);
        request(64'd0);
        tick();
        pulse_cs();
        check_load(100, 100, 24'h000100);

        // T5 out-of-range index on the 8-entry instance
        u_if8.adm_wr = 1'b1; u_if8.adm_wr_id = 4'd15; u_if8.adm_wr_data = 20'h5;
        tick();
        u_if8.adm_wr = 1'b0;
        check("t5_id_range_err", {63'b0, u_if8.cfg_err}, 64'd1);
        u_if8.adm_wr = 1'b1; u_if8.adm_wr_id = 4'd7;
        tick();
        u_if8.adm_wr = 1'b0;
        check("t5_id_ok_no_err", {63'b0, u_if8.cfg_err}, 64'd0);

        // T6 re-arm while pending
        u_if.sync_time_ptp_ns_mini = 64'd0;
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 4'(i), 20'hFFFFF);
            exp_time[i] = 20'hFFFFF;
        end
        request(64'd5000);
        repeat (5) tick();
        request(64'd9000);
        wait_ptp(64'd5040, seen);
        check("t6_no_early", {63'b0, seen}, 64'd0);
        check("t6_pending", {63'b0, u_if.cfg_pending}, 64'd1);
        pulse_cs();
        check("t6_cs_in_pend", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
        wait_ptp(64'd9024, seen);
        check("t6_no_early2", {63'b0, seen}, 64'd0);
        pulse_cs();
        check_load(100, 100, 24'hFFFFF0);

        // T3 far change time
        u_if.sync_time_ptp_ns_mini = 64'h300_0000 - 64'd200;
        request(64'h300_0000);
        pulse_cs();
        check("t3_cs_ignored", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
        wait_ptp(64'h300_0000, seen);
        check("t3_no_early", {63'b0, seen}, 64'd0);
        repeat (2) tick();
        check("t3_pre_cs", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
        pulse_cs();
        check_load(100, 100, 24'hFFFFF0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
